// File: rtl/micro_debug_ctl.sv
// Run-control and monitor block for the micro core: halt / single-step / run-N /
// free-run with a PC breakpoint, a registered monitor mux and a retire counter.
module micro_debug_ctl #(
  parameter  int DATA_W = 16,
  parameter  int NSRC   = 4,
  parameter  int PC_W   = 16,
  parameter  int STEP_W = 8,
  parameter  int CNT_W  = 24,
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_req,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic [STEP_W-1:0]      run_count,
  input  logic                   bp_en,
  input  logic [PC_W-1:0]        bp_addr,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] mon_in,
  output logic                   pc_en,
  output logic                   halted,
  output logic                   bp_hit,
  output logic [DATA_W-1:0]      monitor_value,
  output logic [CNT_W-1:0]       retired
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_STEP,
    ST_RUN_N,
    ST_RUN_FREE
  } state_t;

  state_t              state, state_next;
  logic [STEP_W-1:0]   remaining, remaining_next;
  logic                bp_hit_next;
  logic                skip_bp;
  logic                running;
  logic                bp_stop;
  logic [DATA_W-1:0]   mon_sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HALT;
      remaining <= '0;
      bp_hit    <= 1'b0;
      skip_bp   <= 1'b1;
      retired   <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      bp_hit    <= bp_hit_next;
      skip_bp   <= (state == ST_HALT);
      if (pc_en) retired <= retired + CNT_W'(1);
    end
  end

  // The breakpoint is masked on the first cycle out of HALT so a run started
  // sitting on bp_addr can move past it.
  assign running = (state == ST_RUN_N) || (state == ST_RUN_FREE);
  assign bp_stop = running && bp_en && (pc_in == bp_addr) && !skip_bp;
  assign halted  = (state == ST_HALT);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    bp_hit_next    = bp_hit;
    pc_en          = 1'b0;
    case (state)
      ST_HALT: begin
        if (step_req) begin
          state_next  = ST_STEP;
          bp_hit_next = 1'b0;
        end else if (run_req) begin
          bp_hit_next = 1'b0;
          if (run_count != '0) begin
            state_next     = ST_RUN_N;
            remaining_next = run_count;
          end else begin
            state_next = ST_RUN_FREE;
          end
        end
      end
      ST_STEP: begin
        pc_en      = 1'b1;
        state_next = ST_HALT;
      end
      ST_RUN_N: begin
        pc_en = !bp_stop;
        if (pc_en) remaining_next = remaining - STEP_W'(1);
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (bp_stop) begin
          state_next  = ST_HALT;
          bp_hit_next = 1'b1;
        end else if (remaining == STEP_W'(1)) begin
          state_next = ST_HALT;
        end
      end
      ST_RUN_FREE: begin
        pc_en = !bp_stop;
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (bp_stop) begin
          state_next  = ST_HALT;
          bp_hit_next = 1'b1;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // Out-of-range selects match no source and read as zero.
  always_comb begin
    mon_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) mon_sel = mon_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) monitor_value <= '0;
    else        monitor_value <= mon_sel;
  end

endmodule

// File: tb/tb_micro_debug_ctl.sv
// Directed self-checking bench for micro_debug_ctl: step, run-N, free-run,
// breakpoint with skip-first, halt, request collisions, monitor mux and reset.
module tb_micro_debug_ctl;

  localparam int DATA_W = 16;
  localparam int NSRC   = 4;
  localparam int PC_W   = 16;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 24;
  localparam int SEL_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   step_req, run_req, halt_req, bp_en;
  logic [STEP_W-1:0]      run_count;
  logic [PC_W-1:0]        bp_addr, pc_in;
  logic [SEL_W-1:0]       sel;
  logic [NSRC*DATA_W-1:0] mon_in;
  logic                   pc_en, halted, bp_hit;
  logic [DATA_W-1:0]      monitor_value;
  logic [CNT_W-1:0]       retired;

  int total = 0;
  int bad   = 0;

  micro_debug_ctl #(
    .DATA_W(DATA_W), .NSRC(NSRC), .PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_req(step_req), .run_req(run_req),
    .halt_req(halt_req), .run_count(run_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_in(pc_in), .sel(sel), .mon_in(mon_in), .pc_en(pc_en), .halted(halted),
    .bp_hit(bp_hit), .monitor_value(monitor_value), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] src [NSRC];

  initial begin
    rst_n = 1'b0; step_req = 0; run_req = 0; halt_req = 0; bp_en = 0;
    run_count = '0; bp_addr = '0; pc_in = '0; sel = '0; mon_in = '0;
    src[0] = 16'hA1A1; src[1] = 16'hB2B2; src[2] = 16'hC3C3; src[3] = 16'hD4D4;

    // Reset state
    #12;
    check("rst_pc_en",   pc_en,         0);
    check("rst_halted",  halted,        1);
    check("rst_bp_hit",  bp_hit,        0);
    check("rst_monitor", monitor_value, 0);
    check("rst_retired", retired,       0);
    #1 rst_n = 1'b1;
    tick();

    // Single step
    step_req = 1; #1;
    check("step_pre_pc_en", pc_en, 0);
    tick(); step_req = 0; #1;
    check("step_pc_en",  pc_en,  1);
    check("step_halted", halted, 0);
    tick(); #1;
    check("step_done_pc_en",  pc_en,   0);
    check("step_done_halted", halted,  1);
    check("step_retired",     retired, 1);

    // Run 5
    run_req = 1; run_count = 8'd5;
    tick(); run_req = 0; run_count = 8'd0; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("run5_pc_en_%0d", i), pc_en, 1);
      tick(); #1;
    end
    check("run5_end_pc_en",  pc_en,   0);
    check("run5_end_halted", halted,  1);
    check("run5_retired",    retired, 6);
    check("run5_bp_hit",     bp_hit,  0);

    // Free-run into breakpoint at 0x0010 starting from 0x000C
    bp_en = 1; bp_addr = 16'h0010; pc_in = 16'h000C;
    run_req = 1; run_count = 8'd0;
    tick(); run_req = 0;
    for (int i = 0; i < 4; i++) begin
      pc_in = PC_W'(16'h000C + i); #1;
      check($sformatf("bp_run_pc_en_%0d", i), pc_en, 1);
      tick();
    end
    pc_in = 16'h0010; #1;
    check("bp_match_pc_en", pc_en, 0);
    tick(); #1;
    check("bp_halted",  halted,  1);
    check("bp_hit_set", bp_hit,  1);
    check("bp_retired", retired, 10);

    // Restart on the breakpoint address: skip-first lets it advance
    run_req = 1;
    tick(); run_req = 0; #1;
    check("bp_skip_pc_en",   pc_en,  1);
    check("bp_skip_cleared", bp_hit, 0);
    tick(); pc_in = 16'h0011; halt_req = 1; #1;
    check("bp_past_pc_en", pc_en, 1);
    tick(); halt_req = 0; #1;
    check("bp_stop_halted", halted,  1);
    check("bp_stop_retired", retired, 12);

    // Free-run with halt_req in run cycle 7
    bp_en = 0; run_req = 1;
    tick(); run_req = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) halt_req = 1;
      #1;
      check($sformatf("halt_run_pc_en_c%0d", c), pc_en, 1);
      tick();
    end
    halt_req = 0; #1;
    check("halt_c8_pc_en",  pc_en,   0);
    check("halt_c8_halted", halted,  1);
    check("halt_bp_hit",    bp_hit,  0);
    check("halt_retired",   retired, 19);

    // step + run together, sitting on an armed breakpoint: step only
    bp_en = 1; pc_in = 16'h0010; step_req = 1; run_req = 1; run_count = 8'd5;
    tick(); step_req = 0; run_req = 0; run_count = 8'd0; #1;
    check("collide_pc_en", pc_en, 1);
    tick(); #1;
    check("collide_halted",  halted,  1);
    check("collide_retired", retired, 20);

    // run_req during RUN_N is ignored
    bp_en = 0; run_req = 1; run_count = 8'd3;
    tick(); run_count = 8'd9; #1;
    check("rn3_c1_pc_en", pc_en, 1);
    tick(); run_req = 0; run_count = 8'd0; #1;
    check("rn3_c2_pc_en", pc_en, 1);
    tick(); #1;
    check("rn3_c3_pc_en", pc_en, 1);
    tick(); #1;
    check("rn3_done_halted", halted,  1);
    check("rn3_done_pc_en",  pc_en,   0);
    check("rn3_retired",     retired, 23);

    // Monitor mux sweep
    mon_in = {src[3], src[2], src[1], src[0]};
    for (int s = 0; s < NSRC; s++) begin
      sel = SEL_W'(s);
      tick(); #1;
      check($sformatf("mon_sel%0d", s), monitor_value, src[s]);
    end
    sel = 2'd1; #1;
    check("mon_latency_hold", monitor_value, src[3]);
    tick(); #1;
    check("mon_latency_next", monitor_value, src[1]);
    mon_in[1*DATA_W +: DATA_W] = 16'h5A5A;
    tick(); #1;
    check("mon_data_update", monitor_value, 16'h5A5A);

    // Async reset mid-run
    run_req = 1; run_count = 8'd0;
    tick(); run_req = 0; #1;
    check("rstmid_pre_pc_en", pc_en, 1);
    #1 rst_n = 1'b0; #1;
    check("rstmid_pc_en",   pc_en,         0);
    check("rstmid_halted",  halted,        1);
    check("rstmid_bp_hit",  bp_hit,        0);
    check("rstmid_monitor", monitor_value, 0);
    check("rstmid_retired", retired,       0);
    #1 rst_n = 1'b1;
    tick(); #1;
    check("rstmid_rel_halted", halted, 1);
    check("rstmid_rel_pc_en",  pc_en,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
